// File: rtl/rx_fifo_reg_if.sv
// Bus bundle between the word-side producer and the cipher-side
// block consumer of the receive FIFO.
interface rx_fifo_reg_if;
    logic         clear;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic [127:0] blk_out;
    logic         blk_valid;
    logic         blk_read;
    logic         full;
    logic         empty;
    logic [2:0]   count;
    logic [1:0]   word_side;

    modport master (
        output clear, word_in, word_valid, blk_read,
        input  word_ready, blk_out, blk_valid,
        input  full, empty, count, word_side
    );

    modport slave (
        input  clear, word_in, word_valid, blk_read,
        output word_ready, blk_out, blk_valid,
        output full, empty, count, word_side
    );
endinterface

// File: rtl/rx_fifo_reg.sv
// Receive block FIFO: packs 32-bit words, first word most significant,
// into 128-bit blocks and buffers up to six of them for the cipher core.
module rx_fifo_reg (
    input  logic          clk,
    input  logic          n_rst,
    rx_fifo_reg_if.slave  bus
);
    localparam logic [2:0] DEPTH = 3'd6;
    localparam logic [2:0] LAST  = 3'd5;

    // Packed [0:3] keeps slot 0 in the top 32 bits of each entry.
    logic [0:3][31:0] r_arr [6];
    logic [2:0]       r_head;
    logic [2:0]       r_tail;
    logic [1:0]       r_side;
    logic [2:0]       r_count;

    logic       w_ready;
    logic       w_accept;
    logic       w_commit;
    logic       w_pop;
    logic [2:0] w_head_nxt;
    logic [2:0] w_tail_nxt;

    assign w_ready    = (r_count < DEPTH);
    assign w_accept   = bus.word_valid && w_ready;
    assign w_commit   = w_accept && (r_side == 2'd3);
    assign w_pop      = bus.blk_read && (r_count != 3'd0);
    assign w_head_nxt = (r_head == LAST) ? 3'd0 : r_head + 3'd1;
    assign w_tail_nxt = (r_tail == LAST) ? 3'd0 : r_tail + 3'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head  <= 3'd0;
            r_tail  <= 3'd0;
            r_side  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                r_arr[i] <= '0;
            end
        end else if (bus.clear) begin
            r_head  <= 3'd0;
            r_tail  <= 3'd0;
            r_side  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_accept) begin
                r_arr[r_tail][r_side] <= bus.word_in;
                r_side <= r_side + 2'd1;
            end
            if (w_commit) begin
                r_tail <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_commit && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_commit) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    assign bus.word_ready = w_ready;
    assign bus.blk_out    = r_arr[r_head];
    assign bus.blk_valid  = (r_count != 3'd0);
    assign bus.empty      = (r_count == 3'd0);
    assign bus.full       = (r_count == DEPTH);
    assign bus.count      = r_count;
    assign bus.word_side  = r_side;
endmodule

// File: tb/tb_rx_fifo_reg.sv
// Directed bench for rx_fifo_reg with a block scoreboard queue.
// Expected blocks are queued as words are driven and checked on pop.
module tb_rx_fifo_reg;
    logic clk;
    logic n_rst;

    rx_fifo_reg_if bus ();

    rx_fifo_reg dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks;
    int           errors;
    int           m_count;
    int           m_side;
    logic [127:0] m_cur;
    logic [127:0] q [$];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_side  = 0;
        m_cur   = '0;
        q.delete();
    endtask

    task automatic check_state();
        chk("count",      128'(bus.count),      128'(m_count));
        chk("word_side",  128'(bus.word_side),  128'(m_side));
        chk("word_ready", 128'(bus.word_ready), 128'(m_count < 6));
        chk("full",       128'(bus.full),       128'(m_count == 6));
        chk("empty",      128'(bus.empty),      128'(m_count == 0));
        chk("blk_valid",  128'(bus.blk_valid),  128'(m_count != 0));
        if (q.size() > 0) chk("head_blk", bus.blk_out, q[0]);
    endtask

    task automatic step(input logic v, input logic [31:0] w,
                        input logic rd, input logic clr);
        bit acc;
        bit pop;
        bus.word_valid = v;
        bus.word_in    = w;
        bus.blk_read   = rd;
        bus.clear      = clr;
        acc = v && (m_count < 6);
        pop = rd && (m_count != 0);
        if (pop && !clr) chk("pop_data", bus.blk_out, q[0]);
        @(posedge clk);
        #1;
        bus.word_valid = 1'b0;
        bus.blk_read   = 1'b0;
        bus.clear      = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_count--;
            end
            if (acc) begin
                m_cur[127 - 32*m_side -: 32] = w;
                if (m_side == 3) begin
                    q.push_back(m_cur);
                    m_count++;
                    m_side = 0;
                end else begin
                    m_side++;
                end
            end
        end
        check_state();
    endtask

    task automatic put_block(input logic [31:0] base);
        for (int k = 0; k < 4; k++) step(1'b1, base + 32'(k), 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (m_count > 0) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        n_rst          = 1'b0;
        bus.clear      = 1'b0;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.blk_read   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("rst_blk_out", bus.blk_out, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single block assembly and pop
        step(1'b1, 32'h00010203, 1'b0, 1'b0);
        step(1'b1, 32'h04050607, 1'b0, 1'b0);
        step(1'b1, 32'h08090A0B, 1'b0, 1'b0);
        step(1'b1, 32'h0C0D0E0F, 1'b0, 1'b0);
        chk("t1_blk", bus.blk_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_valid", 128'(bus.blk_valid), 128'd1);
        chk("t1_count", 128'(bus.count), 128'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_empty", 128'(bus.empty), 128'd1);

        // Fill to full, drop a 25th word, recover with one pop
        for (int i = 0; i < 24; i++)
            step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        chk("t2_full", 128'(bus.full), 128'd1);
        chk("t2_ready", 128'(bus.word_ready), 128'd0);
        chk("t2_count", 128'(bus.count), 128'd6);
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_recover", 128'(bus.word_ready), 128'd1);
        drain();

        // Ten blocks streamed with interleaved pops, wrapping pointers
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 4; k++)
                step(1'b1, 32'h2000_0000 + 32'(b*4 + k),
                     (k == 0 && b >= 3) ? 1'b1 : 1'b0, 1'b0);
        drain();

        // Commit and pop in the same cycle at count=2
        put_block(32'h3000_0000);
        put_block(32'h3000_0010);
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h3000_0020 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h3000_0023, 1'b1, 1'b0);
        chk("t4_count", 128'(bus.count), 128'd2);
        chk("t4_side", 128'(bus.word_side), 128'd0);
        drain();

        // Asynchronous reset mid-block
        step(1'b1, 32'h5555_0000, 1'b0, 1'b0);
        step(1'b1, 32'h5555_0001, 1'b0, 1'b0);
        #3;
        n_rst = 1'b0;
        #1;
        chk("t5_ready", 128'(bus.word_ready), 128'd1);
        chk("t5_valid", 128'(bus.blk_valid), 128'd0);
        chk("t5_empty", 128'(bus.empty), 128'd1);
        chk("t5_full", 128'(bus.full), 128'd0);
        chk("t5_count", 128'(bus.count), 128'd0);
        chk("t5_side", 128'(bus.word_side), 128'd0);
        chk("t5_blk", bus.blk_out, 128'h0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b1, 32'hA0000001, 1'b0, 1'b0);
        step(1'b1, 32'hA0000002, 1'b0, 1'b0);
        step(1'b1, 32'hA0000003, 1'b0, 1'b0);
        step(1'b1, 32'hA0000004, 1'b0, 1'b0);
        chk("t5_blk_after", bus.blk_out,
            128'hA0000001_A0000002_A0000003_A0000004);
        drain();

        // Clear beats a simultaneous word and pop
        put_block(32'h4000_0000);
        put_block(32'h4000_0010);
        put_block(32'h4000_0020);
        step(1'b1, 32'h4000_0030, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0BAD0, 1'b1, 1'b1);
        chk("t6_count", 128'(bus.count), 128'd0);
        chk("t6_side", 128'(bus.word_side), 128'd0);
        chk("t6_empty", 128'(bus.empty), 128'd1);
        put_block(32'h6000_0000);
        chk("t6_blk", bus.blk_out, 128'h60000000_60000001_60000002_60000003);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_fifo_reg.md
# rx_fifo_reg

Receive-side block FIFO for the encryption datapath. It accepts 32-bit words from the bus-slave side and packs each group of four into a 128-bit block. It buffers up to six complete blocks and presents the oldest block to the cipher core with a valid/read handshake. It is the mirror of the transmit FIFO, which splits 128-bit blocks into 32-bit words.

## Interface

Parameters: none. Fixed geometry: 6 block entries, 4 words per block, 32-bit words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- n_rst  in  1  asynchronous reset, active-low
- clear  in  1  synchronous flush; discards all stored and partially assembled data
- word_in  in  32  incoming data word
- word_valid  in  1  word_in is valid this cycle
- word_ready  out  1  FIFO can accept a word this cycle
- blk_out  out  128  oldest complete block, valid while blk_valid=1
- blk_valid  out  1  at least one complete block is stored
- blk_read  in  1  pop the oldest block; honoured only when blk_valid=1
- full  out  1  six complete blocks are stored
- empty  out  1  no complete blocks are stored
- count  out  3  number of complete blocks stored, 0..6
- word_side  out  2  index of the next word slot within the block being assembled

## Operation

- Storage: 6 entries × 4 words × 32 bits. Word slot 0 maps to block bits [127:96], slot 1 to [95:64], slot 2 to [63:32] and slot 3 to [31:0]. The first word received is therefore the most significant.
- State:
  - tail_ptr (0..5): entry being assembled
  - word_side (0..3): next slot in that entry
  - head_ptr (0..5): oldest complete entry
  - count (0..6)
- Word accept: occurs when word_valid=1 and word_ready=1.
  - word_in is written to arr[tail_ptr][word_side].
  - word_side increments.
  - On an accept with word_side=3, the block commits: word_side returns to 0, tail_ptr advances and count increments.
- word_ready = (count < 6). While count=6, the tail entry is occupied by an unread block and no words are accepted. word_valid with word_ready=0 is ignored and nothing is written.
- Pop: occurs when blk_read=1 and blk_valid=1. head_ptr advances and count decrements. blk_read while empty is ignored; no pointer or count change.
- Pointer wrap: both tail_ptr and head_ptr advance 5 → 0. The values 6 and 7 are never reached.
- Commit and pop in the same cycle: both pointers advance and count is unchanged.
- Output decode:
  - blk_out = arr[head_ptr], combinational from registered state
  - blk_valid = (count != 0)
  - empty = (count == 0)
  - full = (count == 6)
- A partially assembled block is never visible and is not included in count.
- clear: has priority over word accept and pop in the same cycle. It sets head_ptr, tail_ptr, word_side and count to 0. Array contents are left unchanged.
- Reset (n_rst=0, asynchronous): pointers, word_side and count go to 0 and all array entries go to 0. The resulting outputs are:
  - word_ready=1
  - blk_valid=0
  - empty=1
  - full=0
  - count=0
  - word_side=0
  - blk_out=0
- Reset asserted in the middle of a block discards the partial block. Assembly after reset starts at slot 0.

## Timing

- All state is registered, and every output is a function of registered state only. There is no combinational path from input to output.
- Word-to-block latency: the fourth word is accepted on edge N. From the cycle after edge N, blk_valid=1 and blk_out holds the block.
- Pop: blk_read is sampled at edge N. From the cycle after edge N, blk_out shows the next block, or blk_valid=0.
- Full recovery: a pop at edge N while count=6 gives word_ready=1 in the cycle after edge N.
- Throughput: 1 word per cycle in and 1 block per cycle out. Sustained streaming with count between 1 and 5 never stalls.
- Back-to-back words are accepted with no bubble, including across block boundaries.

## Test plan

- Reset, then write 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on consecutive cycles. Required response: blk_valid=1 one cycle after the fourth word, blk_out=0x000102030405060708090A0B0C0D0E0F, count=1. A pop then returns count=0 and empty=1.
- Write 24 words with no reads. Required response: count=6, full=1, word_ready=0. A 25th word presented with word_valid is dropped, confirmed by unchanged contents. One pop makes word_ready=1 on the next cycle.
- Write and read 10 blocks with incrementing contents, interleaved so that the pointers wrap past 5. Required response: every block is read out in order with exact data, and count never exceeds 6.
- Hold count=2 and commit a fourth word in the same cycle as blk_read=1. Required response: count stays 2, head_ptr and tail_ptr each advance by 1, and word_side returns to 0.
- Write 2 words, then drive n_rst low asynchronously, mid-cycle. Required response: all outputs take their reset values immediately. The next 4 words form a block whose first word is at bits [127:96].
- Hold count=3 with 1 partial word, then assert clear together with word_valid and blk_read. Required response: next cycle count=0, word_side=0, empty=1, and the word presented in the clear cycle is discarded.
